// File: rtl/odometer_pkg.sv
// Shared constants for the odometer control-latch sequencer.
package odometer_pkg;

  localparam int unsigned CTRL_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_LOAD_LO = 3'd3,
    ST_MEAS    = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

endpackage : odometer_pkg

// File: rtl/odometer_scan_sr.sv
// Serial-in/parallel-out configuration shift register; bit 0 is the entry point.
module odometer_scan_sr
  import odometer_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              scan_in,
  output logic [0:CTRL_W-1] ctrl,
  output logic              scan_out
);

  logic [0:CTRL_W-1] shift_q;
  logic [0:CTRL_W-1] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (shift_en) begin
      shift_d = {scan_in, shift_q[0:CTRL_W-2]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign ctrl     = shift_q;
  assign scan_out = shift_q[CTRL_W-1];

endmodule : odometer_scan_sr

// File: rtl/odometer_seq.sv
// Load-and-measure sequencer: shifts in a control word, strobes LOAD, runs a
// programmable MEAS_EN window and ends with a one-cycle DONE.
module odometer_seq
  import odometer_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              SCAN_CLK,
  input  logic              RESETB,
  input  logic              SCAN_IN,
  input  logic              SCAN_EN,
  input  logic              START,
  input  logic [CNT_W-1:0]  WIN_LEN,
  output logic [0:CTRL_W-1] CTRL_IN,
  output logic              SCAN_OUT,
  output logic              LOAD,
  output logic              MEAS_EN,
  output logic              DONE,
  output logic              BUSY
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             meas_q, meas_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             shift_en_c;

  // The word is frozen once a sequence is running.
  assign shift_en_c = (state_q == ST_IDLE) && SCAN_EN;

  odometer_scan_sr #(
    .CTRL_W (CTRL_W)
  ) u_scan_sr (
    .clk      (SCAN_CLK),
    .rst_n    (RESETB),
    .shift_en (shift_en_c),
    .scan_in  (SCAN_IN),
    .ctrl     (CTRL_IN),
    .scan_out (SCAN_OUT)
  );

  // State, window counter and output flops.
  always_ff @(posedge SCAN_CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      meas_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      meas_q  <= meas_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; the counter holds the cycles of window still to run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_PRE;
          cnt_d   = WIN_LEN;
        end
      end
      ST_PRE:     state_d = ST_LOAD_HI;
      ST_LOAD_HI: state_d = ST_LOAD_LO;
      ST_LOAD_LO: state_d = (cnt_q != '0) ? ST_MEAS : ST_DONE;
      ST_MEAS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave straight from flops.
  always_comb begin
    load_d = 1'b0;
    meas_d = 1'b0;
    done_d = 1'b0;
    busy_d = 1'b0;
    load_d = (state_d == ST_LOAD_HI);
    meas_d = (state_d == ST_MEAS);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  assign LOAD    = load_q;
  assign MEAS_EN = meas_q;
  assign DONE    = done_q;
  assign BUSY    = busy_q;

endmodule : odometer_seq
